// File: rtl/pim_weight_load_ctrl.sv
// Weight-load sequencer: stages one 256-bit row from a 16-bit producer, bursts it to the
// bitline driver and strobes the wordline. Optional abort path: define PIM_WLOAD_ABORT_EN.
module pim_weight_load_ctrl #(
    parameter int ROW_AW    = 4,
    parameter int WR_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              i_start,
    input  logic [ROW_AW-1:0] i_row_base,
    input  logic [ROW_AW:0]   i_num_rows,
    input  logic              i_wdata_valid,
    input  logic [15:0]       i_wdata,
    output logic              o_wdata_ready,
`ifdef PIM_WLOAD_ABORT_EN
    input  logic              i_abort,
    output logic              o_abort_ack,
`endif
    output logic              o_weight_in_en,
    output logic [3:0]        o_counter,
    output logic [15:0]       o_data,
    output logic              o_weight_out_en,
    output logic              o_wl_en,
    output logic [ROW_AW-1:0] o_wl_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic [2:0]        o_dbg_state
);

    // Handshake: a word transfers on a rising CLK edge where i_wdata_valid and
    // o_wdata_ready are both 1; valid may be raised or dropped freely by the producer.

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_BURST  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_WRITE  = 3'd4
    } state_t;

    localparam logic [3:0]      WR_LAST  = 4'(WR_CYCLES - 1);
    localparam logic [3:0]      SEG_LAST = 4'hF;
    localparam logic [ROW_AW:0] ONE_ROW  = (ROW_AW + 1)'(1);

    state_t              state_q, state_d;
    logic [3:0]          seg_q, seg_d;
    logic [ROW_AW-1:0]   row_addr_q, row_addr_d;
    logic [ROW_AW:0]     rows_left_q, rows_left_d;
    logic [3:0]          wr_cnt_q, wr_cnt_d;
    logic [255:0]        stage_q, stage_d;

    logic                ready_q, ready_d;
    logic                in_en_q, in_en_d;
    logic [3:0]          counter_q, counter_d;
    logic [15:0]         data_q, data_d;
    logic                out_en_q, out_en_d;
    logic                wl_en_q, wl_en_d;
    logic [ROW_AW-1:0]   wl_addr_q, wl_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                abort_ack_q, abort_ack_d;

    logic                accept;
    logic                abort_now;
    logic [7:0]          wr_msb;
    logic [7:0]          rd_msb;

`ifdef PIM_WLOAD_ABORT_EN
    assign abort_now = i_abort && (state_q != ST_IDLE);
`else
    assign abort_now = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        row_addr_d  = row_addr_q;
        rows_left_d = rows_left_q;
        wr_cnt_d    = wr_cnt_q;
        stage_d     = stage_q;
        done_d      = 1'b0;
        abort_ack_d = 1'b0;
        accept      = (state_q == ST_LOAD) && i_wdata_valid;
        // Segment 0 lives in the top 16 bits of the staged row.
        wr_msb      = 8'd255 - {seg_q, 4'h0};

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_num_rows != '0) begin
                        rows_left_d = i_num_rows;
                        row_addr_d  = i_row_base;
                        seg_d       = 4'd0;
                        state_d     = ST_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    stage_d[wr_msb -: 16] = i_wdata;
                    if (seg_q == SEG_LAST) begin
                        seg_d   = 4'd0;
                        state_d = ST_BURST;
                    end else begin
                        seg_d = seg_q + 4'd1;
                    end
                end
            end
            ST_BURST: begin
                if (seg_q == SEG_LAST) begin
                    seg_d   = 4'd0;
                    state_d = ST_SETTLE;
                end else begin
                    seg_d = seg_q + 4'd1;
                end
            end
            ST_SETTLE: begin
                wr_cnt_d = 4'd0;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_cnt_q == WR_LAST) begin
                    rows_left_d = rows_left_q - ONE_ROW;
                    if (rows_left_q != ONE_ROW) begin
                        row_addr_d = row_addr_q + 1'b1;
                        seg_d      = 4'd0;
                        state_d    = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    wr_cnt_d = wr_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_now) begin
            state_d     = ST_IDLE;
            seg_d       = 4'd0;
            wr_cnt_d    = 4'd0;
            stage_d     = '0;
            done_d      = 1'b0;
            abort_ack_d = 1'b1;
        end

        // Outputs are registered from the next state so they line up with it.
        rd_msb    = 8'd255 - {seg_d, 4'h0};
        ready_d   = (state_d == ST_LOAD);
        busy_d    = (state_d != ST_IDLE);
        in_en_d   = (state_d == ST_BURST);
        counter_d = in_en_d ? seg_d : 4'd0;
        data_d    = in_en_d ? stage_d[rd_msb -: 16] : 16'd0;
        out_en_d  = in_en_d && (seg_d == SEG_LAST);
        wl_en_d   = (state_d == ST_WRITE);
        wl_addr_d = wl_en_d ? row_addr_d : wl_addr_q;
        if (abort_now) begin
            wl_addr_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= ST_IDLE;
            seg_q       <= 4'd0;
            row_addr_q  <= '0;
            rows_left_q <= '0;
            wr_cnt_q    <= 4'd0;
            stage_q     <= '0;
            ready_q     <= 1'b0;
            in_en_q     <= 1'b0;
            counter_q   <= 4'd0;
            data_q      <= 16'd0;
            out_en_q    <= 1'b0;
            wl_en_q     <= 1'b0;
            wl_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_ack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            row_addr_q  <= row_addr_d;
            rows_left_q <= rows_left_d;
            wr_cnt_q    <= wr_cnt_d;
            stage_q     <= stage_d;
            ready_q     <= ready_d;
            in_en_q     <= in_en_d;
            counter_q   <= counter_d;
            data_q      <= data_d;
            out_en_q    <= out_en_d;
            wl_en_q     <= wl_en_d;
            wl_addr_q   <= wl_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            abort_ack_q <= abort_ack_d;
        end
    end

    assign o_wdata_ready   = ready_q;
    assign o_weight_in_en  = in_en_q;
    assign o_counter       = counter_q;
    assign o_data          = data_q;
    assign o_weight_out_en = out_en_q;
    assign o_wl_en         = wl_en_q;
    assign o_wl_addr       = wl_addr_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_dbg_state     = state_q;

`ifdef PIM_WLOAD_ABORT_EN
    assign o_abort_ack = abort_ack_q;
`else
    logic unused_abort_ack;
    assign unused_abort_ack = abort_ack_q;
`endif

endmodule

// File: tb/tb_pim_weight_load_ctrl.sv
// Bench for pim_weight_load_ctrl: job table, hand-written reset/abort sequences and random
// jobs, with a negedge monitor scoring driver/wordline activity against a row-level model.
module tb_pim_weight_load_ctrl;

    localparam int ROW_AW    = 4;
    localparam int WR_CYCLES = 2;

    logic              CLK = 1'b0;
    logic              RSTN;
    logic              i_start;
    logic [ROW_AW-1:0] i_row_base;
    logic [ROW_AW:0]   i_num_rows;
    logic              i_wdata_valid;
    logic [15:0]       i_wdata;
    logic              o_wdata_ready;
    logic              o_weight_in_en;
    logic [3:0]        o_counter;
    logic [15:0]       o_data;
    logic              o_weight_out_en;
    logic              o_wl_en;
    logic [ROW_AW-1:0] o_wl_addr;
    logic              o_busy;
    logic              o_done;
    logic [2:0]        o_dbg_state;
`ifdef PIM_WLOAD_ABORT_EN
    logic              i_abort;
    logic              o_abort_ack;
`endif

    pim_weight_load_ctrl #(.ROW_AW(ROW_AW), .WR_CYCLES(WR_CYCLES)) dut (
        .CLK            (CLK),
        .RSTN           (RSTN),
        .i_start        (i_start),
        .i_row_base     (i_row_base),
        .i_num_rows     (i_num_rows),
        .i_wdata_valid  (i_wdata_valid),
        .i_wdata        (i_wdata),
        .o_wdata_ready  (o_wdata_ready),
`ifdef PIM_WLOAD_ABORT_EN
        .i_abort        (i_abort),
        .o_abort_ack    (o_abort_ack),
`endif
        .o_weight_in_en (o_weight_in_en),
        .o_counter      (o_counter),
        .o_data         (o_data),
        .o_weight_out_en(o_weight_out_en),
        .o_wl_en        (o_wl_en),
        .o_wl_addr      (o_wl_addr),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_dbg_state    (o_dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [20:0]       exp_burst_q[$];   // {out_en, counter, data}
    logic [ROW_AW-1:0] exp_wl_q[$];
    logic [15:0]       words[256];
    int                gap_after[256];
    int done_cnt = 0;
    int done_cyc = 0;
    int last_acc = 0;
    int last_burst_end = 0;
    int wl_run = 0;
    bit prev_in_en = 1'b0;
    bit prev_wl_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] all_outs();
        return {2'b00, o_wdata_ready, o_weight_in_en, o_counter, o_data, o_weight_out_en,
                o_wl_en, o_wl_addr, o_busy, o_done};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        if (RSTN) begin
            if (i_wdata_valid && o_wdata_ready) last_acc = cyc + 1;
            if (o_weight_in_en) begin
                if (exp_burst_q.size() == 0) flag_fail("burst_extra");
                else check("burst", {o_weight_out_en, o_counter, o_data}, exp_burst_q.pop_front());
                if (o_counter == 4'd0) check("burst_start", cyc - last_acc, 0);
                else check("burst_contig", prev_in_en, 1);
                if (o_counter == 4'd15) last_burst_end = cyc;
            end else begin
                check("drv_quiet", {o_weight_out_en, o_counter, o_data}, 0);
            end
            if (o_wl_en) begin
                if (!prev_wl_en) begin
                    check("settle_gap", cyc - last_burst_end, 2);
                    wl_run = 0;
                end
                wl_run++;
                if (exp_wl_q.size() == 0) flag_fail("wl_extra");
                else check("wl_addr", o_wl_addr, exp_wl_q.pop_front());
            end else if (prev_wl_en) begin
                check("wl_len", wl_run, WR_CYCLES);
            end
            if (o_wdata_ready) check("ready_excl", o_weight_in_en | o_wl_en, 0);
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_idle", o_busy, 0);
            end
            prev_in_en = o_weight_in_en;
            prev_wl_en = o_wl_en;
        end
    end

    // ---------------- reference model and driver tasks ----------------
    task automatic push_exp(input int base, input int num);
        logic [ROW_AW-1:0] a;
        for (int r = 0; r < num; r++) begin
            for (int s = 0; s < 16; s++)
                exp_burst_q.push_back({1'(s == 15), 4'(s), words[r*16 + s]});
            a = ROW_AW'(base + r);
            for (int w = 0; w < WR_CYCLES; w++) exp_wl_q.push_back(a);
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        logic r;
        int   n;
        i_wdata_valid = 1'b1;
        i_wdata       = w;
        n = 0;
        forever begin
            @(negedge CLK);
            r = o_wdata_ready;
            @(posedge CLK);
            n++;
            if (r) break;
            if (n > 200) begin
                flag_fail("ready_timeout");
                break;
            end
        end
        #1;
        i_wdata_valid = 1'b0;
    endtask

    task automatic start_job(input int base, input int num, output int start_c);
        i_start    = 1'b1;
        i_row_base = ROW_AW'(base);
        i_num_rows = (ROW_AW + 1)'(num);
        @(posedge CLK);
        #1;
        i_start = 1'b0;
        start_c = cyc;
    endtask

    // Called and returns at 1 time unit after a rising edge.
    task automatic run_job(input int base, input int num, input int rs_at,
                           input int exp_lat, input int exp_last);
        int start_c;
        int d0;
        int n;
        d0 = done_cnt;
        push_exp(base, num);
        start_job(base, num, start_c);
        for (int idx = 0; idx < num * 16; idx++) begin
            send_word(words[idx]);
            if (idx == rs_at) begin
                i_start    = 1'b1;
                i_row_base = 4'd9;
                i_num_rows = 5'd3;
                @(posedge CLK);
                #1;
                i_start = 1'b0;
            end
            repeat (gap_after[idx]) begin
                @(posedge CLK);
                #1;
            end
        end
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("done_seen", done_cnt != d0, 1);
        check("latency", done_cyc - start_c, exp_lat);
        repeat (5) @(negedge CLK);
        check("done_once", done_cnt - d0, 1);
        check("burst_q_empty", exp_burst_q.size(), 0);
        check("wl_q_empty", exp_wl_q.size(), 0);
        check("idle_busy", o_busy, 0);
        if (num != 0) check("wl_addr_hold", o_wl_addr, exp_last);
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        int base; int num;
        int ga_at; int ga_len; int gb_at; int gb_len;
        int rs_at; int exp_lat; int exp_last;
    } vec_t;
    vec_t vecs[7];

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        int n;
        int sc;
        int base;
        int num;
        int lat;
        logic [ROW_AW-1:0] last;

        vecs[0] = '{3,  1,  -1, 0, -1, 0, -1, 35,  3};   // single row, back-to-back
        vecs[1] = '{3,  1,   5, 3, 12, 1, -1, 39,  3};   // bubbles
        vecs[2] = '{14, 3,  -1, 0, -1, 0, -1, 105, 0};   // address wrap
        vecs[3] = '{0,  0,  -1, 0, -1, 0, -1, 0,   0};   // zero rows
        vecs[4] = '{2,  1,  -1, 0, -1, 0,  4, 36,  2};   // start while busy
        vecs[5] = '{7,  2,   0, 2, 20, 5, -1, 77,  8};   // bubbles across rows
        vecs[6] = '{15, 16, -1, 0, -1, 0, -1, 560, 14};  // full array

        RSTN = 1'b0;
        i_start = 1'b0;
        i_row_base = '0;
        i_num_rows = '0;
        i_wdata_valid = 1'b0;
        i_wdata = '0;
`ifdef PIM_WLOAD_ABORT_EN
        i_abort = 1'b0;
`endif
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_outs", all_outs(), 0);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        @(posedge CLK);
        #1;

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 256; i++) begin
                words[i] = 16'h1000 + 16'(i);
                gap_after[i] = 0;
            end
            if (vecs[v].ga_at >= 0) gap_after[vecs[v].ga_at] = vecs[v].ga_len;
            if (vecs[v].gb_at >= 0) gap_after[vecs[v].gb_at] = vecs[v].gb_len;
            run_job(vecs[v].base, vecs[v].num, vecs[v].rs_at, vecs[v].exp_lat, vecs[v].exp_last);
        end

        // Reset in the middle of a burst.
        for (int i = 0; i < 256; i++) begin
            words[i] = 16'($urandom);
            gap_after[i] = 0;
        end
        push_exp(5, 2);
        d0 = done_cnt;
        start_job(5, 2, sc);
        for (int i = 0; i < 16; i++) send_word(words[i]);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(o_weight_in_en && o_counter == 4'd7) && n < 60);
        check("rst_reach_cnt7", o_counter, 7);
        RSTN = 1'b0;
        @(negedge CLK);
        check("rst_mid_outs", all_outs(), 0);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        exp_burst_q.delete();
        exp_wl_q.delete();
        repeat (40) @(posedge CLK);
        #1;
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_idle", o_busy, 0);
        for (int i = 0; i < 256; i++) words[i] = 16'h2000 + 16'(i);
        run_job(9, 1, -1, 35, 9);

`ifdef PIM_WLOAD_ABORT_EN
        // Abort on the final WRITE cycle of row 2 of 4.
        for (int i = 0; i < 256; i++) words[i] = 16'($urandom);
        push_exp(0, 2);
        d0 = done_cnt;
        start_job(0, 4, sc);
        for (int i = 0; i < 32; i++) send_word(words[i]);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(o_wl_en && o_wl_addr == 4'd1) && n < 80);
        check("abort_reach_wr", {o_wl_en, o_wl_addr}, {1'b1, 4'd1});
        @(negedge CLK);
        i_abort = 1'b1;
        @(posedge CLK);
        #1;
        i_abort = 1'b0;
        @(negedge CLK);
        check("abort_ack", o_abort_ack, 1);
        check("abort_outs", all_outs(), 0);
        @(negedge CLK);
        check("abort_ack_pulse", o_abort_ack, 0);
        repeat (40) @(negedge CLK);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", o_busy, 0);
        check("abort_q_empty", exp_burst_q.size() + exp_wl_q.size(), 0);
        @(posedge CLK);
        #1;
        i_abort = 1'b1;
        @(posedge CLK);
        #1;
        i_abort = 1'b0;
        @(negedge CLK);
        check("abort_idle_noack", {o_abort_ack, o_busy}, 0);
        @(posedge CLK);
        #1;
`endif

        // Random jobs against the row-level model.
        for (int j = 0; j < 6; j++) begin
            base = $urandom_range(0, 15);
            num  = $urandom_range(1, 3);
            lat  = 35 * num;
            for (int i = 0; i < 256; i++) begin
                words[i] = 16'($urandom);
                gap_after[i] = 0;
                if ((i % 16) != 15 && $urandom_range(0, 3) == 0) begin
                    gap_after[i] = $urandom_range(1, 3);
                    if (i < num * 16) lat += gap_after[i];
                end
            end
            last = ROW_AW'(base + num - 1);
            run_job(base, num, -1, lat, int'(last));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
